// File: rtl/prog_fetch_unit.sv
// rtl/prog_fetch_unit.sv - program store and fetch stage (optional Jump via PROG_FETCH_JUMP_EN)
module prog_fetch_unit #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int NIB   = 4
) (
    input  logic           clk1,
    input  logic           MainClearN,
    input  logic           prog_en,
    input  logic [NIB-1:0] prog_nib,
    input  logic           prog_strobe,
    output logic           prog_done,
    input  logic           fetch_req,
    output logic [NIB-1:0] instr_op,
    output logic [NIB-1:0] instr_arg,
    output logic           instr_valid,
    output logic [AW-1:0]  pc,
    output logic           halt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [NIB-1:0] OP_HALT = {NIB{1'b1}};
`ifdef PROG_FETCH_JUMP_EN
    localparam logic [NIB-1:0] OP_JUMP = NIB'(6);
`endif

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [NIB-1:0]     hi_q, hi_d;
    logic               done_q, done_d;
    logic               halt_q, halt_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic [NIB-1:0]     op_q, op_d;
    logic [NIB-1:0]     arg_q, arg_d;
    logic               wr_en;
    logic [2*NIB-1:0]   mem_q [DEPTH];
    logic [2*NIB-1:0]   rd_word;
    logic [NIB-1:0]     rd_op;
    logic [NIB-1:0]     rd_arg;
    logic               in_load;

    assign rd_word = mem_q[pc_q];
    assign rd_op   = rd_word[2*NIB-1:NIB];
    assign rd_arg  = rd_word[NIB-1:0];
    assign in_load = (state_q == LOAD_HI) || (state_q == LOAD_LO);

    // Next-state logic: programming entry overrides everything; a request seen
    // at one edge (req_q) is served at the following edge from mem[pc].
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        hi_d     = hi_q;
        done_d   = done_q;
        halt_d   = halt_q;
        valid_d  = 1'b0;
        req_d    = 1'b0;
        op_d     = op_q;
        arg_d    = arg_q;
        wr_en    = 1'b0;

        if (prog_en && !in_load) begin
            state_d  = LOAD_HI;
            wr_ptr_d = '0;
            done_d   = 1'b0;
            halt_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_req) begin
                        state_d = RUN;
                        req_d   = 1'b1;
                    end
                end
                RUN: begin
                    req_d = fetch_req;
                    if (req_q) begin
                        op_d    = rd_op;
                        arg_d   = rd_arg;
                        valid_d = 1'b1;
                        if (rd_op == OP_HALT) begin
                            halt_d  = 1'b1;
                            state_d = HALT;
                            req_d   = 1'b0;
`ifdef PROG_FETCH_JUMP_EN
                        end else if (rd_op == OP_JUMP) begin
                            pc_d = rd_arg[AW-1:0];
`endif
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
                LOAD_HI: begin
                    if (!prog_en) begin
                        state_d = IDLE;
                    end else if (prog_strobe) begin
                        hi_d    = prog_nib;
                        state_d = LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (!prog_en) begin
                        state_d = IDLE;
                    end else if (prog_strobe) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = LOAD_HI;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk1 or negedge MainClearN) begin
        if (!MainClearN) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            wr_ptr_q <= '0;
            hi_q     <= '0;
            done_q   <= 1'b0;
            halt_q   <= 1'b0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            op_q     <= '0;
            arg_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            hi_q     <= hi_d;
            done_q   <= done_d;
            halt_q   <= halt_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
        end
    end

    // Program store: cleared to Nop on reset, written one word per low-nibble strobe.
    always_ff @(posedge clk1 or negedge MainClearN) begin
        if (!MainClearN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= {hi_q, prog_nib};
        end
    end

    assign prog_done   = done_q;
    assign instr_op    = op_q;
    assign instr_arg   = arg_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halt        = halt_q;

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
- Program store and instruction fetch stage directly upstream of the 4-bit microprocessor datapath.
- Holds an 8-word x 8-bit program, loaded one nibble at a time over a programming port.
- In run mode, delivers one instruction per fetch request as a 4-bit opcode and a 4-bit operand.
- Opcode encodings match the core decoder: Nop 0000, Add 0001, Sub 0010, Out 0011, In 0100, Load 0101; 1111 is Halt.

Parameters:
DEPTH, 8, number of program words (power of two)
AW, 3, address width, log2(DEPTH)
NIB, 4, nibble width; program words are 2*NIB bits

Ports:
clk1  input  1  system clock, rising-edge active
MainClearN  input  1  asynchronous active-low reset
prog_en  input  1  level; 1 selects programming mode
prog_nib  input  NIB  programming data nibble
prog_strobe  input  1  one-cycle qualifier for prog_nib
prog_done  output  1  all DEPTH words written since the last entry into programming mode
fetch_req  input  1  request for the next instruction, one per cycle maximum
instr_op  output  NIB  fetched opcode, high nibble of the word
instr_arg  output  NIB  fetched operand, low nibble of the word
instr_valid  output  1  one-cycle pulse, instr_op/instr_arg valid
pc  output  AW  address of the next word to fetch
halt  output  1  Halt fetched; fetching stopped

Behaviour:
- Reset (MainClearN=0, asynchronous): state=IDLE; pc=0; wr_ptr=0; hi_reg=0; memory cleared to 0 (Nop).
- Reset values of outputs: prog_done=0, instr_op=0, instr_arg=0, instr_valid=0, halt=0.
- Reset asserted mid-load or mid-run aborts immediately; no partial write survives.
- States: IDLE, LOAD_HI, LOAD_LO, RUN, HALT.
- Priority: prog_en=1 in any state enters LOAD_HI next cycle.
  - On entry: wr_ptr=0, prog_done=0, halt=0, instr_valid=0.
  - Any fetch_req in that cycle is ignored.
- IDLE: with prog_en=0 and fetch_req=1, go to RUN and serve the request in that same cycle (see RUN).
- LOAD_HI: prog_strobe=1 latches prog_nib into hi_reg; go to LOAD_LO.
- LOAD_LO: prog_strobe=1 writes mem[wr_ptr]={hi_reg,prog_nib}, then wr_ptr=wr_ptr+1.
  - If wr_ptr was DEPTH-1: wr_ptr wraps to 0, prog_done=1, go to IDLE.
  - Otherwise go to LOAD_HI.
- prog_en falling in LOAD_HI/LOAD_LO: go to IDLE; a pending high nibble is discarded; words already written are kept; prog_done unchanged.
- prog_done holds until the next entry into programming mode or reset.
- RUN: fetch_req=1 at edge N.
  - At edge N+1: {instr_op,instr_arg}=mem[pc], instr_valid=1, pc=pc+1 (wraps DEPTH-1 to 0).
  - Latency is exactly 1 cycle.
  - Back-to-back requests give a valid pulse every cycle.
  - instr_valid drops after one cycle if no new request.
  - instr_op/instr_arg hold their last value while instr_valid=0.
- Halt: a fetched word with opcode 1111 is still presented with instr_valid=1.
  - pc does NOT increment; halt=1; go to HALT.
- HALT: fetch_req ignored, instr_valid=0. Exit only by reset or prog_en.
- prog_strobe outside LOAD states is ignored.
- fetch_req outside IDLE/RUN is ignored.

Optional Feature:
- Macro: PROG_FETCH_JUMP_EN.
- Defined: opcode 0110 is Jump.
  - The word is presented normally with instr_valid=1.
  - pc loads instr_arg[AW-1:0] instead of incrementing.
  - A jump to its own address is legal and loops.
- Undefined: 0110 is an ordinary opcode; pc increments.

Test Plan:
1. Program words 0x51,0x12,0x23,0x30,0x00,0x00,0x00,0xF0 (16 strobes, high nibble first); prog_en=0; fetch_req held high -> instr_valid pulses 8 cycles with ops 5,1,2,3,0,0,0,F; args 1,2,3,0,0,0,0,0; pc ends at 7; halt=1 one cycle after the 0xF0 fetch; prog_done=1 after the 16th strobe.
2. Program words 0x01..0x08 in sequence; 10 single-cycle fetch_req pulses -> pc sequence 1..7,0,1,2; the 9th fetch returns 0x01 (wrap).
3. Drop prog_en after 5 strobes (2 full words plus one high nibble) -> mem[0], mem[1] written, mem[2] stays 0x00, prog_done=0, state IDLE.
4. Assert prog_en and fetch_req in the same cycle -> no instr_valid; state LOAD_HI; wr_ptr=0.
5. Pull MainClearN low between the two strobes of a word, then release -> pc=0, halt=0, all words read back 0x00.
6. (PROG_FETCH_JUMP_EN) Program mem[2]=0x65 -> after fetching mem[2], pc=5 and the next fetch returns mem[5]; with the macro undefined, pc=3.
